// File: rtl/trap_seq.sv
// Trap sequencer for the M-mode CSR trap path.
// Accepts ecall / mret / timer-irq requests, waits for the instruction to commit,
// serialises mepc/mcause/mstatus writes over the single CSR port, then redirects the IFU.
module trap_seq #(
  parameter int                   CPU_WIDTH   = 32,
  parameter logic [CPU_WIDTH-1:0] CAUSE_ECALL = 32'd11,
  parameter logic [CPU_WIDTH-1:0] CAUSE_TIMER = 32'h80000007
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_ecall,
  input  logic                 i_mret,
  input  logic                 i_irq,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [CPU_WIDTH-1:0] i_mtvec,
  input  logic [CPU_WIDTH-1:0] i_mepc,
  input  logic [CPU_WIDTH-1:0] i_mstatus,
  input  logic                 i_commit_valid,
  output logic                 o_csr_wen,
  output logic [11:0]          o_csr_waddr,
  output logic [CPU_WIDTH-1:0] o_csr_wdata,
  output logic                 o_redirect_valid,
  output logic [CPU_WIDTH-1:0] o_redirect_pc,
  input  logic                 i_redirect_ready,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_COMMIT = 3'd1,
    ST_WR_MEPC     = 3'd2,
    ST_WR_MCAUSE   = 3'd3,
    ST_WR_MSTATUS  = 3'd4,
    ST_REDIRECT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    K_NONE  = 2'd0,
    K_ECALL = 2'd1,
    K_TIMER = 2'd2,
    K_MRET  = 2'd3
  } kind_t;

  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;

  // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M-mode; other bits untouched.
  function automatic logic [CPU_WIDTH-1:0] trap_mstatus(input logic [CPU_WIDTH-1:0] ms);
    logic [CPU_WIDTH-1:0] r;
    r        = ms;
    r[7]     = ms[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap return: MIE <= MPIE, MPIE <= 1, MPP <= M-mode; other bits untouched.
  function automatic logic [CPU_WIDTH-1:0] mret_mstatus(input logic [CPU_WIDTH-1:0] ms);
    logic [CPU_WIDTH-1:0] r;
    r        = ms;
    r[3]     = ms[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  state_t               state_r, state_nxt_s;
  kind_t                kind_r, req_kind_s;
  logic [CPU_WIDTH-1:0] pc_r, mtvec_r, mepc_r, mstatus_r;
  logic                 accept_s;

  logic                 csr_wen_nxt_s, redirect_valid_nxt_s;
  logic [11:0]          csr_waddr_nxt_s;
  logic [CPU_WIDTH-1:0] csr_wdata_nxt_s, redirect_pc_nxt_s;
  logic [CPU_WIDTH-1:0] mcause_s, mstatus_wr_s, redirect_target_s;

  assign accept_s = i_req_valid && (state_r == ST_IDLE);

  // Classify the presented request: ecall beats an enabled irq, which beats mret.
  always_comb begin
    req_kind_s = K_NONE;
    if (i_ecall) begin
      req_kind_s = K_ECALL;
    end else if (i_irq && i_mstatus[3]) begin
      req_kind_s = K_TIMER;
    end else if (i_mret) begin
      req_kind_s = K_MRET;
    end else begin
      req_kind_s = K_NONE;
    end
  end

  // Write data and redirect target derive only from values captured at accept.
  always_comb begin
    mcause_s          = (kind_r == K_TIMER) ? CAUSE_TIMER : CAUSE_ECALL;
    mstatus_wr_s      = (kind_r == K_MRET) ? mret_mstatus(mstatus_r) : trap_mstatus(mstatus_r);
    redirect_target_s = (kind_r == K_MRET) ? mepc_r : {mtvec_r[CPU_WIDTH-1:2], 2'b00};
  end

  // Next-state logic for the trap sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (req_kind_s != K_NONE)) begin
          state_nxt_s = ST_WAIT_COMMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_COMMIT: begin
        if (i_commit_valid) begin
          state_nxt_s = (kind_r == K_MRET) ? ST_WR_MSTATUS : ST_WR_MEPC;
        end else begin
          state_nxt_s = ST_WAIT_COMMIT;
        end
      end
      ST_WR_MEPC:    state_nxt_s = ST_WR_MCAUSE;
      ST_WR_MCAUSE:  state_nxt_s = ST_WR_MSTATUS;
      ST_WR_MSTATUS: state_nxt_s = ST_REDIRECT;
      ST_REDIRECT: begin
        if (i_redirect_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REDIRECT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, so every output is a plain register.
  always_comb begin
    csr_wen_nxt_s        = 1'b0;
    csr_waddr_nxt_s      = 12'h000;
    csr_wdata_nxt_s      = '0;
    redirect_valid_nxt_s = 1'b0;
    redirect_pc_nxt_s    = '0;
    case (state_nxt_s)
      ST_WR_MEPC: begin
        csr_wen_nxt_s   = 1'b1;
        csr_waddr_nxt_s = ADDR_MEPC;
        csr_wdata_nxt_s = pc_r;
      end
      ST_WR_MCAUSE: begin
        csr_wen_nxt_s   = 1'b1;
        csr_waddr_nxt_s = ADDR_MCAUSE;
        csr_wdata_nxt_s = mcause_s;
      end
      ST_WR_MSTATUS: begin
        csr_wen_nxt_s   = 1'b1;
        csr_waddr_nxt_s = ADDR_MSTATUS;
        csr_wdata_nxt_s = mstatus_wr_s;
      end
      ST_REDIRECT: begin
        redirect_valid_nxt_s = 1'b1;
        redirect_pc_nxt_s    = redirect_target_s;
      end
      default: begin
        csr_wen_nxt_s        = 1'b0;
        redirect_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r          <= ST_IDLE;
      o_req_ready      <= 1'b1;
      o_busy           <= 1'b0;
      o_csr_wen        <= 1'b0;
      o_csr_waddr      <= 12'h000;
      o_csr_wdata      <= '0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
    end else begin
      state_r          <= state_nxt_s;
      o_req_ready      <= (state_nxt_s == ST_IDLE);
      o_busy           <= (state_nxt_s != ST_IDLE);
      o_csr_wen        <= csr_wen_nxt_s;
      o_csr_waddr      <= csr_waddr_nxt_s;
      o_csr_wdata      <= csr_wdata_nxt_s;
      o_redirect_valid <= redirect_valid_nxt_s;
      o_redirect_pc    <= redirect_pc_nxt_s;
    end
  end

  // Capture the request context at accept so later input changes cannot leak in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      kind_r    <= K_NONE;
      pc_r      <= '0;
      mtvec_r   <= '0;
      mepc_r    <= '0;
      mstatus_r <= '0;
    end else if (accept_s && (req_kind_s != K_NONE)) begin
      kind_r    <= req_kind_s;
      pc_r      <= i_pc;
      mtvec_r   <= i_mtvec;
      mepc_r    <= i_mepc;
      mstatus_r <= i_mstatus;
    end else begin
      kind_r    <= kind_r;
      pc_r      <= pc_r;
      mtvec_r   <= mtvec_r;
      mepc_r    <= mepc_r;
      mstatus_r <= mstatus_r;
    end
  end

endmodule
